// File: rtl/nv_nvdla_glb_cacc_intr_collector.sv
// GLB-side collector for the CACC done-interrupt channel.
// Retimes the 2-bit done pd, latches sticky W1C status/overflow bits per
// ping-pong group, keeps saturating done counters and drives a registered,
// maskable level interrupt toward the core interrupt aggregator.
module nv_nvdla_glb_cacc_intr_collector #(
    parameter int IN_STAGES = 2,
    parameter int CNT_W     = 8
) (
    input  logic             nvdla_core_clk,
    input  logic             nvdla_core_rst,
    input  logic [1:0]       cacc2glb_done_intr_dst_pd,
    input  logic             reg_mask_wr_en,
    input  logic [1:0]       reg_mask_wr_data,
    input  logic             reg_status_clr_en,
    input  logic [1:0]       reg_status_clr_data,
    input  logic             reg_cnt_clr,
    output logic [1:0]       intr_status,
    output logic [1:0]       intr_mask,
    output logic [1:0]       intr_ovf,
    output logic [CNT_W-1:0] done_cnt0,
    output logic [CNT_W-1:0] done_cnt1,
    output logic             core_intr
);

    // Increment that holds at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    logic [1:0]       evt;
    logic [1:0]       clr;
    logic [1:0]       status_nxt;
    logic [1:0]       ovf_nxt;
    logic [1:0]       mask_nxt;
    logic [CNT_W-1:0] cnt0_nxt;
    logic [CNT_W-1:0] cnt1_nxt;

    // ---- retime stage: pd delayed IN_STAGES cycles becomes evt ----
    generate
        if (IN_STAGES == 0) begin : g_bypass
            assign evt = cacc2glb_done_intr_dst_pd;
        end else begin : g_retime
            logic [1:0] pd_p [IN_STAGES];

            // Shift the done pulses through the retiming flops.
            always_ff @(posedge nvdla_core_clk or posedge nvdla_core_rst) begin
                if (nvdla_core_rst) begin
                    for (int i = 0; i < IN_STAGES; i++) pd_p[i] <= '0;
                end else begin
                    pd_p[0] <= cacc2glb_done_intr_dst_pd;
                    for (int i = 1; i < IN_STAGES; i++) pd_p[i] <= pd_p[i-1];
                end
            end

            assign evt = pd_p[IN_STAGES-1];
        end
    endgenerate

    assign clr = {2{reg_status_clr_en}} & reg_status_clr_data;

    // ---- status / overflow / mask / counter next-state ----
    // Next-state for all sticky state; an event wins over a same-cycle clear,
    // and a clear that coincides with an event consumes the old one (no ovf).
    always_comb begin
        status_nxt = intr_status;
        ovf_nxt    = intr_ovf;
        for (int g = 0; g < 2; g++) begin
            if (evt[g])      status_nxt[g] = 1'b1;
            else if (clr[g]) status_nxt[g] = 1'b0;

            if (evt[g] && intr_status[g] && !clr[g]) ovf_nxt[g] = 1'b1;
            else if (clr[g])                         ovf_nxt[g] = 1'b0;
        end

        mask_nxt = reg_mask_wr_en ? reg_mask_wr_data : intr_mask;

        cnt0_nxt = done_cnt0;
        cnt1_nxt = done_cnt1;
        if (reg_cnt_clr) begin
            cnt0_nxt = '0;
            cnt1_nxt = '0;
        end else begin
            if (evt[0]) cnt0_nxt = sat_inc(done_cnt0);
            if (evt[1]) cnt1_nxt = sat_inc(done_cnt1);
        end
    end

    // ---- register stage: state and interrupt output ----
    // core_intr uses the values being registered so it rises with status.
    always_ff @(posedge nvdla_core_clk or posedge nvdla_core_rst) begin
        if (nvdla_core_rst) begin
            intr_status <= '0;
            intr_ovf    <= '0;
            intr_mask   <= '0;
            done_cnt0   <= '0;
            done_cnt1   <= '0;
            core_intr   <= 1'b0;
        end else begin
            intr_status <= status_nxt;
            intr_ovf    <= ovf_nxt;
            intr_mask   <= mask_nxt;
            done_cnt0   <= cnt0_nxt;
            done_cnt1   <= cnt1_nxt;
            core_intr   <= |(status_nxt & ~mask_nxt);
        end
    end

endmodule
